// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle RISC-V R/I-type sequencer driving an external ALU.
// Optional feature: define ALU_SEQ_XOR_EN to execute funct3 100 (xor) as AND then OR.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_funct3, req_funct7b5      operation select
//   req_a, req_b                  operands (req_b[4:0] is the shift amount)
//   alu_in0, alu_in1, alu_op      external ALU operands and op code (0 when idle)
//   alu_out, alu_of               ALU result bits [30:0] and bit 31
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             result and unsupported-funct3 flag
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct7b5,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_in0,
  output logic [31:0] alu_in1,
  output logic [2:0]  alu_op,
  input  logic [30:0] alu_out,
  input  logic        alu_of,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);
`ifdef ALU_SEQ_XOR_EN
  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, XOR2, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, EXEC, SHIFT, DONE} state_e;
`endif
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
`ifdef ALU_SEQ_XOR_EN
    OP_XOR,
`endif
    OP_BAD
  } op_e;
  state_e      state_q, state_d;
  op_e         op_q, op_d, dec_op;
  logic [31:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  always_comb begin
    dec_op = OP_BAD;
    case (req_funct3)
      3'b000: dec_op = req_funct7b5 ? OP_SUB : OP_ADD;
      3'b111: dec_op = OP_AND;
      3'b110: dec_op = OP_OR;
      3'b010: dec_op = OP_SLT;
      3'b001: dec_op = OP_SLL;
      3'b101: dec_op = OP_SRL;
`ifdef ALU_SEQ_XOR_EN
      3'b100: dec_op = OP_XOR;
`endif
      default: dec_op = OP_BAD;
    endcase
  end
  // r_q doubles as the shift working register, the xor intermediate and the
  // final response data, so only one 32-bit result register is needed.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    alu_in0 = '0;
    alu_in1 = '0;
    alu_op  = '0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        a_d   = req_a;
        b_d   = req_b;
        op_d  = dec_op;
        cnt_d = req_b[4:0];
        err_d = dec_op == OP_BAD;
        r_d   = '0;
        if (dec_op == OP_BAD) state_d = DONE;
        else if (dec_op == OP_SLL || dec_op == OP_SRL) begin
          r_d     = req_a;
          state_d = (req_b[4:0] == 5'd0) ? DONE : SHIFT;
        end else state_d = EXEC;
      end
      EXEC: begin
        alu_in0 = a_q;
        alu_in1 = b_q;
        state_d = DONE;
        case (op_q)
          OP_ADD: begin
            alu_op = 3'd2;
            r_d    = {alu_of, alu_out};
          end
          OP_SUB: begin
            alu_op = 3'd3;
            r_d    = {alu_of, alu_out};
          end
          OP_AND: begin
            alu_op = 3'd0;
            r_d    = {a_q[31] & b_q[31], alu_out};
          end
          OP_OR: begin
            alu_op = 3'd1;
            r_d    = {a_q[31] | b_q[31], alu_out};
          end
          // Signs differ: the negative operand is smaller; otherwise a-b cannot overflow.
          OP_SLT: begin
            alu_op = 3'd3;
            r_d    = {31'b0, (a_q[31] ^ b_q[31]) ? a_q[31] : alu_of};
          end
`ifdef ALU_SEQ_XOR_EN
          OP_XOR: begin
            alu_op  = 3'd0;
            r_d     = {1'b0, alu_out};
            state_d = XOR2;
          end
`endif
          default: r_d = r_q;
        endcase
      end
      SHIFT: begin
        alu_in0 = r_q;
        alu_op  = (op_q == OP_SLL) ? 3'd7 : 3'd6;
        r_d     = (op_q == OP_SLL) ? {r_q[30], alu_out} : {1'b0, alu_out};
        cnt_d   = cnt_q - 5'd1;
        state_d = (cnt_q == 5'd1) ? DONE : SHIFT;
      end
`ifdef ALU_SEQ_XOR_EN
      // a^b = (a|b) & ~(a&b); bit 31 is not produced by the ALU for logic ops.
      XOR2: begin
        alu_in0 = a_q;
        alu_in1 = b_q;
        alu_op  = 3'd1;
        r_d     = {a_q[31] ^ b_q[31], alu_out & ~r_q[30:0]};
        state_d = DONE;
      end
`endif
      DONE: state_d = rsp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rsp_data  = rsp_valid ? r_q : '0;
  assign rsp_err   = rsp_valid & err_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: self-checking bench for alu_sequencer with a behavioural ALU and reference model.
module tb_alu_sequencer;
  logic        clk, rst_n, req_valid, req_ready, req_funct7b5, rsp_valid, rsp_ready, rsp_err, alu_of;
  logic [2:0]  req_funct3, alu_op;
  logic [31:0] req_a, req_b, alu_in0, alu_in1, rsp_data, alu_res;
  logic [30:0] alu_out;
  int errors = 0;
  int checks = 0;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_funct7b5(req_funct7b5), .req_a(req_a), .req_b(req_b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd0: alu_res = alu_in0 & alu_in1;
      3'd1: alu_res = alu_in0 | alu_in1;
      3'd2: alu_res = alu_in0 + alu_in1;
      3'd3: alu_res = alu_in0 - alu_in1;
      3'd4: alu_res = {31'b0, $signed(alu_in0) < $signed(alu_in1)};
      3'd5: alu_res = ~(alu_in0 | alu_in1);
      3'd6: alu_res = alu_in0 >> 1;
      default: alu_res = alu_in0 << 1;
    endcase
  end
  assign alu_out = alu_res[30:0];
  assign alu_of  = alu_res[31];

  function automatic void model(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] d, output logic e, output int lat);
    e = 1'b0;
    lat = 2;
    d = '0;
    case (f3)
      3'b000: d = f7 ? a - b : a + b;
      3'b111: d = a & b;
      3'b110: d = a | b;
      3'b010: d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b001: begin d = a << b[4:0]; lat = (b[4:0] == 0) ? 1 : int'(b[4:0]) + 1; end
      3'b101: begin d = a >> b[4:0]; lat = (b[4:0] == 0) ? 1 : int'(b[4:0]) + 1; end
`ifdef ALU_SEQ_XOR_EN
      3'b100: begin d = a ^ b; lat = 3; end
`endif
      default: begin e = 1'b1; lat = 1; end
    endcase
  endfunction

  task automatic do_op(input logic [2:0] f3, input logic f7, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] d, output logic e, output int lat, output int n_sll, output int n_srl,
                       output logic stable, output logic rdy_done, output logic rdy_after);
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = f3;
    req_funct7b5 = f7;
    req_a = a;
    req_b = b;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    n_sll = 0;
    n_srl = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 200) begin
      if (alu_op == 3'd7) n_sll++;
      if (alu_op == 3'd6) n_srl++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) begin
      errors++;
      $display("FAIL timeout: rsp_valid never rose within %0d cycles", lat);
    end
    d = rsp_data;
    e = rsp_err;
    rdy_done = req_ready;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (rsp_data !== d || rsp_err !== e || rsp_valid !== 1'b1) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    rdy_after = req_ready;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, alu_in0, alu_in1, alu_op} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b data=%h in0=%h in1=%h op=%0d want all 0",
               rsp_valid, rsp_err, rsp_data, alu_in0, alu_in1, alu_op);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_sub;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b000, 1'b1, 32'h7FFFFFFF, 32'h80000000, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'hFFFFFFFF || e !== 1'b0) begin errors++; $display("FAIL sub: data=%h err=%b want FFFFFFFF 0", d, e); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL sub_latency: got %0d want 2", lat); end
    checks++;
    if (rd !== 1'b0) begin errors++; $display("FAIL done_ready: req_ready=%b in DONE want 0", rd); end
  endtask

  task automatic test_shift;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b001, 1'b0, 32'h40000001, 32'd4, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'h00000010) begin errors++; $display("FAIL sll: data=%h want 00000010", d); end
    checks++;
    if (ns != 4 || nr != 0) begin errors++; $display("FAIL sll_cycles: op7=%0d op6=%0d want 4 0", ns, nr); end
    checks++;
    if (lat != 5) begin errors++; $display("FAIL sll_latency: got %0d want 5", lat); end
    do_op(3'b101, 1'b0, 32'h80000000, 32'd31, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'h00000001 || nr != 31) begin errors++; $display("FAIL srl: data=%h op6=%0d want 00000001 31", d, nr); end
    do_op(3'b001, 1'b0, 32'hDEADBEEF, 32'hFFFFFFE0, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'hDEADBEEF || lat != 1 || ns != 0) begin
      errors++;
      $display("FAIL shamt0: data=%h lat=%0d alu_cycles=%0d want DEADBEEF 1 0", d, lat, ns);
    end
  endtask

  task automatic test_slt;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b010, 1'b0, 32'h80000000, 32'h00000001, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'd1) begin errors++; $display("FAIL slt_neg: data=%h want 1", d); end
    do_op(3'b010, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL slt_pos: data=%h want 0", d); end
  endtask

  task automatic test_and_hold;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b111, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 5, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'hF000F000) begin errors++; $display("FAIL and: data=%h want F000F000", d); end
    checks++;
    if (st !== 1'b1) begin errors++; $display("FAIL and_hold: stable=%b want 1", st); end
    checks++;
    if (ra !== 1'b1) begin errors++; $display("FAIL and_ready_after: got %b want 1", ra); end
  endtask

  task automatic test_unsupported;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b011, 1'b0, 32'h12345678, 32'h9ABCDEF0, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'd0 || e !== 1'b1 || lat != 1) begin
      errors++;
      $display("FAIL unsupported: data=%h err=%b lat=%0d want 0 1 1", d, e, lat);
    end
  endtask

  task automatic test_xor;
    logic [31:0] d, xd; logic e, xe, st, rd, ra; int lat, xl, ns, nr;
    model(3'b100, 1'b0, 32'h0000FFFF, 32'h00FF00FF, xd, xe, xl);
    do_op(3'b100, 1'b0, 32'h0000FFFF, 32'h00FF00FF, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== xd || e !== xe || lat != xl) begin
      errors++;
      $display("FAIL xor: data=%h err=%b lat=%0d want %h %b %0d", d, e, lat, xd, xe, xl);
    end
  endtask

  task automatic test_reset_mid_shift;
    logic no_valid;
    @(negedge clk);
    req_valid = 1'b1;
    req_funct3 = 3'b001;
    req_funct7b5 = 1'b0;
    req_a = 32'h12345678;
    req_b = 32'd10;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (alu_op !== 3'd7 || alu_in0 !== 32'h48D159E0) begin
      errors++;
      $display("FAIL mid_shift: op=%0d in0=%h want 7 48D159E0", alu_op, alu_in0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_err, rsp_data, alu_in0, alu_in1, alu_op} !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_shift: valid=%b err=%b data=%h in0=%h in1=%h op=%0d ready=%b want 0s ready 1",
               rsp_valid, rsp_err, rsp_data, alu_in0, alu_in1, alu_op, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_shift_release_ready: got %b want 1", req_ready); end
    no_valid = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) no_valid = 1'b0;
    end
    checks++;
    if (no_valid !== 1'b1) begin errors++; $display("FAIL mid_shift_discard: rsp_valid seen after reset, want none"); end
  endtask

  task automatic test_random;
    logic [31:0] a, b, d, xd; logic [2:0] f3; logic f7, e, xe, st, rd, ra; int lat, xl, ns, nr, hold;
    for (int i = 0; i < 150; i++) begin
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = {a[31], {31{a[0]}}};
      hold = $urandom_range(0, 2);
      model(f3, f7, a, b, xd, xe, xl);
      do_op(f3, f7, a, b, hold, d, e, lat, ns, nr, st, rd, ra);
      checks++;
      if (d !== xd || e !== xe) begin
        errors++;
        $display("FAIL rand_data[%0d]: f3=%0d f7=%b a=%h b=%h data=%h err=%b want %h %b", i, f3, f7, a, b, d, e, xd, xe);
      end
      checks++;
      if (lat != xl) begin errors++; $display("FAIL rand_latency[%0d]: f3=%0d got %0d want %0d", i, f3, lat, xl); end
      checks++;
      if (st !== 1'b1 || rd !== 1'b0 || ra !== 1'b1) begin
        errors++;
        $display("FAIL rand_handshake[%0d]: stable=%b ready_in_done=%b ready_after=%b want 1 0 1", i, st, rd, ra);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d; logic e, st, rd, ra; int lat, ns, nr;
    do_op(3'b000, 1'b0, 32'h00000005, 32'h00000007, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'd12 || ra !== 1'b1) begin errors++; $display("FAIL b2b_first: data=%h ready=%b want 0000000C 1", d, ra); end
    do_op(3'b110, 1'b0, 32'h80000001, 32'h00000002, 0, d, e, lat, ns, nr, st, rd, ra);
    checks++;
    if (d !== 32'h80000003 || lat != 2) begin errors++; $display("FAIL b2b_second: data=%h lat=%0d want 80000003 2", d, lat); end
  endtask

  initial begin
    req_valid = 1'b0;
    req_funct3 = '0;
    req_funct7b5 = 1'b0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    test_reset;
    test_sub;
    test_shift;
    test_slt;
    test_and_hold;
    test_unsupported;
    test_xor;
    test_reset_mid_shift;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
